hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised hazard and forwarding controller for the MIPS pipeline. It replaces the fixed two-source negedge forwarding compare in the processor top.
- Keeps a shadow pipeline of in-flight destination info, one slot per stage from EX up to and including WB.
- Produces registered ALU operand forward selects, load-use stall/bubble, and multi-cycle branch flush.
- Sits beside the ID/EX boundary: consumes decode fields, drives the ID/EX operand muxes and the PC/IF-ID hold logic.

Parameters:
- REG_ADDR_W, 5: register address width.
- FWD_DEPTH, 2: number of post-EX stages that can forward (1 = EX/MEM, 2 = MEM/WB, ...). Must be >= 1.
- LOAD_LAT, 1: extra slots before load data can be forwarded. Must satisfy 0 <= LOAD_LAT < FWD_DEPTH.
- FLUSH_CYCLES, 2: bubbles inserted after a taken branch. Must be >= 1.
- FSEL_W, $clog2(FWD_DEPTH+1): forward select width (derived).

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous active-high reset.
- id_valid, in, 1: a real instruction is in ID.
- id_rs, in, REG_ADDR_W: source A address.
- id_rt, in, REG_ADDR_W: source B address.
- id_use_rs, in, 1: instruction reads rs.
- id_use_rt, in, 1: instruction reads rt.
- id_dest, in, REG_ADDR_W: destination, already muxed rd/rt.
- id_we, in, 1: instruction writes the register file.
- id_is_load, in, 1: result comes from data memory.
- ex_br_taken, in, 1: branch resolved taken in EX.
- fwd_a, out, FSEL_W: operand A select for the instruction in EX (0 = reg file, k = stage k after EX).
- fwd_b, out, FSEL_W: operand B select, same encoding.
- stall, out, 1: hold PC and IF/ID.
- bubble, out, 1: ID/EX loads a NOP.
- flush, out, 1: kill IF/ID and ID/EX contents.

Behaviour:
- Shadow slots: slot[0] = EX, slot[1..FWD_DEPTH] = following stages; slot[FWD_DEPTH] is WB. Each slot holds {valid, dest, we, is_load}.
- Every posedge: slot[k] <= slot[k-1] for k >= 1. slot[0] <= ID info when it issues, otherwise an invalid bubble.
- Issue condition: id_valid & !stall & !flush.
- Match of a source s against slot j: slot valid & we & dest == s & s != 0 & the matching use flag is set. Register 0 is never forwarded and never causes a stall.
- Load-use stall (combinational): any source matches a slot j < LOAD_LAT whose is_load = 1. Result: stall = bubble = 1; ID is held and slot[0] becomes a bubble.
- Forward select (registered at issue): fwd_x <= smallest (j+1) over matching slots j in 0..FWD_DEPTH-1, else 0. The youngest producer wins. When there is no issue, fwd_a and fwd_b <= 0.
- No forward from slot[FWD_DEPTH]. The register file is write-through in that cycle.
- Branch: ex_br_taken is qualified by slot[0].valid, so bubbles never branch.
  - flush = taken_q | (flush_cnt != 0), where taken_q is the qualified ex_br_taken.
  - On taken_q: flush_cnt <= FLUSH_CYCLES-1. A taken_q during the count reloads the counter.
  - Otherwise flush_cnt decrements to 0 and holds.
- Priority: flush over stall. stall and bubble are forced to 0 while flush = 1, and the ID instruction is discarded.
- Latency: fwd valid the cycle after issue, i.e. aligned with the instruction in EX. stall and flush are combinational, same cycle.
- Reset (async): all slots invalid, fwd_a = fwd_b = 0, flush_cnt = 0. Hence stall = bubble = flush = 0.
- Reset mid-flush or mid-stall aborts immediately. The first cycle after release behaves as an empty pipeline.

Optional Feature:
- HAZ_STATS_EN defined: adds outputs stall_cnt[15:0] and flush_cnt_total[15:0].
  - stall_cnt counts cycles with stall = 1; flush_cnt_total counts cycles with flush = 1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - forward select localparams FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2;
  - the slot record typedef {valid, dest, we, is_load};
  - a parameter legality check function.
- One sub-module, hazard_slot_pipe: the FWD_DEPTH+1 deep shadow shift register with bubble-insert input, exposing all slots.
- Match, priority and flush logic stay in the top module.

Test Plan:
- Back-to-back ALU ops: add r3 <- r1,r2, then sub r4 <- r3,r5 -> second cycle in EX has fwd_a = 1, fwd_b = 0, stall = 0.
- Distance 2: add r3, nop, and r6 <- r2,r3 -> fwd_b = 2. At distance 3 -> fwd_b = 0.
- Load-use: lw r7, then add r8 <- r7,r1 with LOAD_LAT = 1 -> stall = bubble = 1 for exactly 1 cycle, then fwd_a = 2.
- Branch: taken beq in EX with FLUSH_CYCLES = 2 -> flush = 1 for 2 cycles. A load-use hazard present in those cycles shows stall = 0.
- Register 0 and double producers: add r0 then use r0 -> fwd_a = 0, no stall. Two writers to r3 at slots 0 and 1 -> fwd = 1, youngest wins.
- Async reset asserted mid-flush, between clock edges -> flush, stall, fwd_a and fwd_b go to 0 immediately. With HAZ_STATS_EN, the counters clear to 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit: forward select
// encodings, the shadow slot record and a parameter legality check.
package hazard_pkg;

  localparam int unsigned FWD_RF    = 0;
  localparam int unsigned FWD_EXMEM = 1;
  localparam int unsigned FWD_MEMWB = 2;

  // Slot dest field is sized for the widest supported register address.
  localparam int unsigned SLOT_DEST_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_DEST_W-1:0] dest;
    logic                   we;
    logic                   is_load;
  } slot_t;

  function automatic bit params_ok(input int unsigned reg_addr_w,
                                   input int unsigned fwd_depth,
                                   input int unsigned load_lat,
                                   input int unsigned flush_cycles);
    return (reg_addr_w >= 1) && (reg_addr_w <= SLOT_DEST_W) &&
           (fwd_depth >= 1) && (load_lat < fwd_depth) && (flush_cycles >= 1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Decode-side / control-side bundle of the hazard unit.
// Optional statistics ports appear when HAZ_STATS_EN is defined.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_DEPTH  = 2
);
  localparam int unsigned FSEL_W = $clog2(FWD_DEPTH + 1);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_we;
  logic                  id_is_load;
  logic                  ex_br_taken;
  logic [FSEL_W-1:0]     fwd_a;
  logic [FSEL_W-1:0]     fwd_b;
  logic                  stall;
  logic                  bubble;
  logic                  flush;
`ifdef HAZ_STATS_EN
  logic [15:0]           stall_cnt;
  logic [15:0]           flush_cnt_total;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_we, id_is_load,
           ex_br_taken,
    input  fwd_a, fwd_b, stall, bubble, flush, stall_cnt, flush_cnt_total
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_we, id_is_load,
           ex_br_taken,
    output fwd_a, fwd_b, stall, bubble, flush, stall_cnt, flush_cnt_total
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_we, id_is_load,
           ex_br_taken,
    input  fwd_a, fwd_b, stall, bubble, flush
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_we, id_is_load,
           ex_br_taken,
    output fwd_a, fwd_b, stall, bubble, flush
  );
`endif

endinterface

// File: rtl/hazard_slot_pipe.sv
// Shadow shift register of in-flight destination info, slot 0 = EX up to
// slot DEPTH = WB; a non-issuing cycle inserts an invalid bubble at slot 0.
module hazard_slot_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  issue_i,
  input  slot_t slot_i,
  output slot_t slots_o [DEPTH+1]
);

  slot_t slots_q [DEPTH+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k <= DEPTH; k++) slots_q[k] <= '0;
    end else begin
      slots_q[0] <= issue_i ? slot_i : '0;
      for (int unsigned k = 1; k <= DEPTH; k++) slots_q[k] <= slots_q[k-1];
    end
  end

  assign slots_o = slots_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: registered ALU forward selects, load-use
// stall/bubble and multi-cycle branch flush. Optional counters: HAZ_STATS_EN.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FWD_DEPTH    = 2,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  hazard_forward_unit_if.slave bus
);

  localparam int unsigned FSEL_W = $clog2(FWD_DEPTH + 1);
  localparam int unsigned CNT_W  = $clog2(FLUSH_CYCLES) + 1;
  localparam bit PARAMS_OK = params_ok(REG_ADDR_W, FWD_DEPTH, LOAD_LAT, FLUSH_CYCLES);

  if (!PARAMS_OK) begin : g_bad_params
    $error("hazard_forward_unit: illegal parameter combination");
  end

  slot_t             slots [FWD_DEPTH+1];
  slot_t             id_slot;
  logic [FWD_DEPTH-1:0] match_a;
  logic [FWD_DEPTH-1:0] match_b;
  logic              load_hit;
  logic              taken;
  logic              flush_w;
  logic              stall_w;
  logic              issue;
  logic [FSEL_W-1:0] fwd_a_d, fwd_a_q;
  logic [FSEL_W-1:0] fwd_b_d, fwd_b_q;
  logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;

  assign id_slot = '{valid:   1'b1,
                     dest:    SLOT_DEST_W'(bus.id_dest),
                     we:      bus.id_we,
                     is_load: bus.id_is_load};

  hazard_slot_pipe #(.DEPTH(FWD_DEPTH)) u_slot_pipe (
    .clk     (clk),
    .rst     (rst),
    .issue_i (issue),
    .slot_i  (id_slot),
    .slots_o (slots)
  );

  // Source matching against forwardable slots; register 0 never matches.
  always_comb begin
    match_a  = '0;
    match_b  = '0;
    load_hit = 1'b0;
    fwd_a_d  = FSEL_W'(FWD_RF);
    fwd_b_d  = FSEL_W'(FWD_RF);
    for (int unsigned j = 0; j < FWD_DEPTH; j++) begin
      match_a[j] = slots[j].valid & slots[j].we & bus.id_use_rs &
                   (bus.id_rs != '0) & (slots[j].dest == SLOT_DEST_W'(bus.id_rs));
      match_b[j] = slots[j].valid & slots[j].we & bus.id_use_rt &
                   (bus.id_rt != '0) & (slots[j].dest == SLOT_DEST_W'(bus.id_rt));
    end
    for (int unsigned j = 0; j < LOAD_LAT; j++) begin
      load_hit = load_hit | ((match_a[j] | match_b[j]) & slots[j].is_load);
    end
    // Walk oldest to youngest so the youngest producer wins.
    for (int j = int'(FWD_DEPTH); j >= 1; j--) begin
      if (match_a[j-1]) fwd_a_d = FSEL_W'(j);
      if (match_b[j-1]) fwd_b_d = FSEL_W'(j);
    end
  end

  assign taken   = bus.ex_br_taken & slots[0].valid;
  assign flush_w = taken | (flush_cnt_q != '0);
  assign stall_w = load_hit & ~flush_w;
  assign issue   = bus.id_valid & ~stall_w & ~flush_w;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (taken) begin
      flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= issue ? fwd_a_d : '0;
      fwd_b_q     <= issue ? fwd_b_d : '0;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fwd_a  = fwd_a_q;
  assign bus.fwd_b  = fwd_b_q;
  assign bus.stall  = stall_w;
  assign bus.bubble = stall_w;
  assign bus.flush  = flush_w;

`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt_q, flush_tot_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_tot_q <= '0;
    end else begin
      if (stall_w && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_w && flush_tot_q != 16'hFFFF) flush_tot_q <= flush_tot_q + 16'd1;
    end
  end

  assign bus.stall_cnt       = stall_cnt_q;
  assign bus.flush_cnt_total = flush_tot_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (default parameters).
module tb_hazard_forward_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  hazard_forward_unit_if #(.REG_ADDR_W(5), .FWD_DEPTH(2)) bus ();

  hazard_forward_unit #(
    .REG_ADDR_W(5), .FWD_DEPTH(2), .LOAD_LAT(1), .FLUSH_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic we, input logic ld);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_use_rs  = urs;
    bus.id_use_rt  = urt;
    bus.id_dest    = dest;
    bus.id_we      = we;
    bus.id_is_load = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    bus.ex_br_taken = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.ex_br_taken = 1'b0;
    #2;
    checks++;
    if (bus.fwd_a !== 2'd0 || bus.fwd_b !== 2'd0 || bus.stall !== 1'b0 ||
        bus.bubble !== 1'b0 || bus.flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got fwd_a=%0d fwd_b=%0d stall=%0b bubble=%0b flush=%0b exp all 0",
               bus.fwd_a, bus.fwd_b, bus.stall, bus.bubble, bus.flush);
    end
`ifdef HAZ_STATS_EN
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt_total !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt_total);
    end
`endif
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.flush !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got flush=%0b stall=%0b exp 0/0", bus.flush, bus.stall);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);   // add r3 <- r1,r2
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL b2b_stall0 got=%0b exp=0", bus.stall);
    end
    step();
    drive(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0);   // sub r4 <- r3,r5
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL b2b_stall1 got=%0b exp=0", bus.stall);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.fwd_a !== 2'd1 || bus.fwd_b !== 2'd0) begin
      errors++; $display("FAIL b2b_fwd got a=%0d b=%0d exp a=1 b=0", bus.fwd_a, bus.fwd_b);
    end
    drain();
  endtask

  task automatic test_distance();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);   // add r3
    step();
    idle();
    step();
    drive(1, 5'd2, 5'd3, 1, 1, 5'd6, 1, 0);   // and r6 <- r2,r3
    step();
    idle();
    #1;
    checks++;
    if (bus.fwd_a !== 2'd0 || bus.fwd_b !== 2'd2) begin
      errors++; $display("FAIL dist2_fwd got a=%0d b=%0d exp a=0 b=2", bus.fwd_a, bus.fwd_b);
    end
    drain();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    step();
    idle();
    step();
    step();
    drive(1, 5'd2, 5'd3, 1, 1, 5'd6, 1, 0);
    step();
    idle();
    #1;
    checks++;
    if (bus.fwd_b !== 2'd0) begin
      errors++; $display("FAIL dist3_fwd got b=%0d exp b=0", bus.fwd_b);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);   // lw r7
    step();
    drive(1, 5'd7, 5'd1, 1, 1, 5'd8, 1, 0);   // add r8 <- r7,r1
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.bubble !== 1'b1) begin
      errors++; $display("FAIL lu_stall got stall=%0b bubble=%0b exp 1/1", bus.stall, bus.bubble);
    end
    step();
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.bubble !== 1'b0 || bus.fwd_a !== 2'd0) begin
      errors++;
      $display("FAIL lu_release got stall=%0b bubble=%0b fwd_a=%0d exp 0/0/0",
               bus.stall, bus.bubble, bus.fwd_a);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.fwd_a !== 2'd2 || bus.fwd_b !== 2'd0) begin
      errors++; $display("FAIL lu_fwd got a=%0d b=%0d exp a=2 b=0", bus.fwd_a, bus.fwd_b);
    end
    drain();
  endtask

  task automatic test_branch_flush();
    drive(1, 5'd1, 5'd0, 1, 0, 5'd7, 1, 1);   // load sitting in EX when branch resolves
    step();
    drive(1, 5'd7, 5'd1, 1, 1, 5'd8, 1, 0);   // load-use hazard in ID
    bus.ex_br_taken = 1'b1;
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
      errors++;
      $display("FAIL br_cycle1 got flush=%0b stall=%0b bubble=%0b exp 1/0/0",
               bus.flush, bus.stall, bus.bubble);
    end
    step();                                   // taken stays high but EX holds a bubble
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.stall !== 1'b0 || bus.fwd_a !== 2'd0) begin
      errors++;
      $display("FAIL br_cycle2 got flush=%0b stall=%0b fwd_a=%0d exp 1/0/0",
               bus.flush, bus.stall, bus.fwd_a);
    end
    step();
    bus.ex_br_taken = 1'b0;
    #1;
    checks++;
    if (bus.flush !== 1'b0 || bus.fwd_a !== 2'd0) begin
      errors++; $display("FAIL br_end got flush=%0b fwd_a=%0d exp 0/0", bus.flush, bus.fwd_a);
    end
    drain();
  endtask

  task automatic test_reg0_and_double();
    drive(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);   // lw r0
    step();
    drive(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0);   // add r9 <- r0,r0
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL r0_stall got=%0b exp=0", bus.stall);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.fwd_a !== 2'd0 || bus.fwd_b !== 2'd0) begin
      errors++; $display("FAIL r0_fwd got a=%0d b=%0d exp 0/0", bus.fwd_a, bus.fwd_b);
    end
    drain();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);   // add r3
    step();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);   // add r3 again
    step();
    drive(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);   // sub r4 <- r3,r3
    step();
    idle();
    #1;
    checks++;
    if (bus.fwd_a !== 2'd1 || bus.fwd_b !== 2'd1) begin
      errors++; $display("FAIL double_fwd got a=%0d b=%0d exp 1/1", bus.fwd_a, bus.fwd_b);
    end
    drain();
  endtask

  task automatic test_reset_mid_flush();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);   // add r3
    step();
    drive(1, 5'd3, 5'd4, 1, 1, 5'd0, 0, 0);   // beq r3,r4
    step();
    idle();
    bus.ex_br_taken = 1'b1;
    #1;
    checks++;
    if (bus.flush !== 1'b1 || bus.fwd_a !== 2'd1) begin
      errors++; $display("FAIL mid_pre got flush=%0b fwd_a=%0d exp 1/1", bus.flush, bus.fwd_a);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.flush !== 1'b0 || bus.stall !== 1'b0 || bus.fwd_a !== 2'd0 || bus.fwd_b !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got flush=%0b stall=%0b fwd_a=%0d fwd_b=%0d exp all 0",
               bus.flush, bus.stall, bus.fwd_a, bus.fwd_b);
    end
`ifdef HAZ_STATS_EN
    checks++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt_total !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_stats got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt_total);
    end
`endif
    bus.ex_br_taken = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.flush !== 1'b0 || bus.fwd_a !== 2'd0) begin
      errors++; $display("FAIL mid_release got flush=%0b fwd_a=%0d exp 0/0", bus.flush, bus.fwd_a);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_branch_flush();
    test_reg0_and_double();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
